// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder for the req/gnt/rvalid data-request protocol.
//            A single-port word RAM with byte enables. Grants come after a
//            programmable number of wait states. Every accepted request gets
//            one response after a fixed latency. Out-of-range accesses
//            complete with error_o set.
// Params   : BASE_ADDR  - byte address of word 0
//            DEPTH_LOG2 - RAM holds 2**DEPTH_LOG2 32-bit words
//            GNT_WAIT   - req_i-high cycles before gnt_o (0..15)
//            LATENCY    - cycles from accept edge to rvalid_o (1..8)
// Ports    : clk       in      clock, rising edge
//            reset     in      synchronous, active-high
//            req_i     in      request valid
//            addr_i    in  32  byte address, bits [1:0] ignored
//            wdata_i   in  32  write data
//            we_i      in      1 = write, 0 = read
//            be_i      in  4   write byte enables
//            gnt_o     out     request accepted this cycle
//            rvalid_o  out     one-cycle response pulse
//            rdata_o   out 32  read data (0 unless rvalid_o on a read)
//            error_o   out     out-of-range access (0 unless rvalid_o)
// Config   : STALL_INJECT_EN - when defined, an LFSR randomly withholds gnt_o
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        error_o
);

  localparam int unsigned c_DEPTH    = 2**DEPTH_LOG2;
  localparam logic [3:0]  c_WAIT_TGT = 4'(GNT_WAIT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_nxt;
  logic        w_stall;
  logic        w_gnt;
  logic        w_accept;

  // --------------------------------------------------------------------------
  // Optional grant stall injection
  // --------------------------------------------------------------------------
`ifdef STALL_INJECT_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; the newest bit lands in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_gnt          = 1'b0;
    if (w_stall) begin
      // Stalled cycle: no grant, FSM and wait counter frozen.
      w_gnt = 1'b0;
    end else if (GNT_WAIT == 0) begin
      w_gnt = req_i;
    end else begin
      case (r_state)
        S_IDLE: begin
          // The first req_i-high cycle counts as wait cycle 1.
          if (req_i) begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = 4'd1;
          end
        end
        S_WAIT: begin
          if (!req_i) begin
            w_state_nxt    = S_IDLE;
            w_wait_cnt_nxt = 4'd0;
          end else if (r_wait_cnt == c_WAIT_TGT) begin
            w_gnt          = 1'b1;
            w_state_nxt    = S_IDLE;
            w_wait_cnt_nxt = 4'd0;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_wait_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  assign gnt_o    = w_gnt;
  assign w_accept = req_i & w_gnt;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0]           w_offset;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_unused;

  // The subtraction wraps modulo 2**32, so addresses below BASE_ADDR fall out of range.
  assign w_offset   = addr_i - BASE_ADDR;
  assign w_in_range = (w_offset >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign w_idx      = w_offset[DEPTH_LOG2+1:2];
  assign w_unused   = ^w_offset[1:0];

  // --------------------------------------------------------------------------
  // Word RAM (not reset)
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [c_DEPTH];

  always_ff @(posedge clk) begin
    if (w_accept && we_i && w_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline
  // --------------------------------------------------------------------------
  // Idle stages carry zero data and zero error, so the outputs are 0 without an extra gate.
  logic        r_pv [LATENCY];
  logic        r_pe [LATENCY];
  logic [31:0] r_pd [LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= 32'd0;
      end
    end else begin
      r_pv[0] <= w_accept;
      r_pe[0] <= w_accept & ~w_in_range;
      r_pd[0] <= (w_accept && !we_i && w_in_range) ? r_mem[w_idx] : 32'd0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign rvalid_o = r_pv[LATENCY-1];
  assign error_o  = r_pe[LATENCY-1];
  assign rdata_o  = r_pd[LATENCY-1];

endmodule
`default_nettype wire
